// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, defaults and one-hot helper for the demux dispatcher
package demux_pkg;
  localparam int N_OUT_DEF = 8;
  localparam int DW_DEF    = 8;

  typedef enum logic {IDLE, HOLD} disp_state_e;

  // Wide enough for any channel count up to 32; callers truncate to N_OUT.
  function automatic logic [31:0] onehot(input logic [4:0] sel);
    return 32'd1 << sel;
  endfunction
endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - first set mask bit at or after ptr, wrapping
module rr_next_sel #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [W-1:0] sel,
  output logic         any
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {mask, mask} >> ptr;
    rot = dbl[N-1:0];
    sel = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sel = ptr + W'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - one-word holding dispatcher onto N_OUT channels
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DW    = DW_DEF,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [N_OUT-1:0] chan_en,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_dest,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_valid,
  output logic [DW-1:0]    out_data,
  input  logic [N_OUT-1:0] out_ready,
  output logic [7:0]       drop_cnt,
  output logic [SEL_W-1:0] rr_ptr
);
  disp_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    data_q, data_d;
  logic [7:0]       drop_q, drop_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_sel;
  logic             rr_any;
  logic             out_fire, accept, drop, load;
  logic [SEL_W-1:0] new_sel;

  rr_next_sel #(.N(N_OUT), .W(SEL_W)) u_rr (
    .ptr (ptr_q),
    .mask(chan_en),
    .sel (rr_sel),
    .any (rr_any)
  );

  assign out_fire  = (state_q == HOLD) && out_ready[sel_q];
  // Pass-through acceptance: a new word may enter in the cycle the held one leaves.
  assign in_ready  = ((state_q == IDLE) || out_fire) && (mode || rr_any);
  assign accept    = in_valid && in_ready;
  assign new_sel   = mode ? in_dest : rr_sel;
  assign drop      = accept && mode && !chan_en[in_dest];
  assign load      = accept && !drop;

  assign out_valid = (state_q == HOLD) ? N_OUT'(onehot(5'(sel_q))) : '0;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;
  assign rr_ptr    = ptr_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    drop_d  = drop_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = HOLD;
      sel_d   = new_sel;
      data_d  = in_data;
    end else if (out_fire) begin
      state_d = IDLE;
    end
    if (accept && !mode) begin
      ptr_d = rr_sel + SEL_W'(1);
    end
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      drop_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - scoreboard bench for demux_dispatcher
module tb_demux_dispatcher;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] chan_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [7:0] drop_cnt;
  logic [2:0] rr_ptr;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  demux_dispatcher dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .chan_en  (chan_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt),
    .rr_ptr   (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb.push_back(e);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid != 8'h00) begin
          checks++;
          if (!$onehot(out_valid)) begin
            errors++;
            $display("FAIL out_onehot: got %0h expected one bit", out_valid);
          end
        end
        for (int k = 0; k < 8; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_xfer: got ch %0d data %0h expected none", k, out_data);
            end else begin
              e = sb.pop_front();
              if (e.ch != 3'(k) || e.d != out_data) begin
                errors++;
                $display("FAIL xfer: got ch %0d data %0h expected ch %0d data %0h",
                         k, out_data, e.ch, e.d);
              end
            end
          end
        end
      end
    end
  end

  logic [2:0] t2_ch [4];

  initial begin
    t2_ch[0] = 3'd0; t2_ch[1] = 3'd2; t2_ch[2] = 3'd7; t2_ch[3] = 3'd0;
    mode      = 1'b0;
    chan_en   = 8'hFF;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dest   = 3'd0;
    out_ready = 8'hFF;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_drop_cnt", drop_cnt, 8'h00);
    chk("rst_rr_ptr", rr_ptr, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    step();

    // Round-robin, all enabled, back-to-back
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(negedge clk);
      chk("t1_in_ready", in_ready, 1'b1);
      if (in_ready) push(3'(i % 8), 8'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t1_rr_ptr", rr_ptr, 3'd2);

    // Round-robin with sparse mask, wrap 7->0
    do_reset();
    chan_en = 8'b1000_0101;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1'b1);
      if (in_ready) push(t2_ch[i], 8'h10 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t2_rr_ptr", rr_ptr, 3'd1);

    // Directed with backpressure on channel 5
    do_reset();
    mode      = 1'b1;
    chan_en   = 8'hFF;
    out_ready = 8'hDF;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    in_dest   = 3'd5;
    @(negedge clk);
    chk("t3_first_ready", in_ready, 1'b1);
    if (in_ready) push(3'd5, 8'hA5);
    step();
    in_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 8'h20);
      chk("t3_hold_data", out_data, 8'hA5);
      chk("t3_hold_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 8'hFF;
    @(negedge clk);
    chk("t3_pass_ready", in_ready, 1'b1);
    if (in_ready) push(3'd5, 8'h5A);
    step();
    in_valid = 1'b0;
    step();
    step();

    // Directed drops to disabled channel 3, saturation
    do_reset();
    mode    = 1'b1;
    chan_en = 8'hF7;
    in_dest = 3'd3;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      @(negedge clk);
      chk("t4_in_ready", in_ready, 1'b1);
      chk("t4_no_valid", out_valid, 8'h00);
      if (i == 100 || i == 255) chk("t4_drop_mid", drop_cnt, 32'(i));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drop_sat", drop_cnt, 8'hFF);
    step();

    // Round-robin with nothing enabled
    do_reset();
    mode    = 1'b0;
    chan_en = 8'h00;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      @(negedge clk);
      chk("t5_in_ready", in_ready, 1'b0);
      chk("t5_no_valid", out_valid, 8'h00);
      step();
    end
    in_valid = 1'b0;
    chk("t5_rr_ptr", rr_ptr, 3'd0);

    // Reset while holding a word
    do_reset();
    mode     = 1'b1;
    chan_en  = 8'hFE;
    in_dest  = 3'd0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    step();
    mode      = 1'b0;
    chan_en   = 8'hFF;
    out_ready = 8'h00;
    in_data   = 8'h77;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_held_valid", out_valid, 8'h01);
    chk("t6_drop_pre", drop_cnt, 8'h01);
    chk("t6_ptr_pre", rr_ptr, 3'd1);
    step();
    do_reset();
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 8'h00);
    chk("t6_rst_ptr", rr_ptr, 3'd0);
    chk("t6_rst_drop", drop_cnt, 8'h00);
    step();
    out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
